// File: rtl/btb_ctrl.sv
// btb_ctrl: arbitrates the single BTB RAM port between fetch lookups and
// execute-stage updates, and sweeps every entry to CLR_VALUE after reset or flush.
//
// Handshakes: a lookup is accepted when i_lkp_valid && o_lkp_ready are both high
// in the same cycle. Its result appears one cycle later with o_lkp_rvalid.
// An update is accepted when i_upd_valid && o_upd_ready are both high.
// Neither ready signal looks at its own valid input.
module btb_ctrl #(
    parameter int                   ADDR_W    = 10,
    parameter int                   DATA_W    = 32,
    parameter int                   UPD_DEPTH = 2,
    parameter logic [DATA_W-1:0]    CLR_VALUE = '0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_lkp_valid,
    input  logic [ADDR_W-1:0] i_lkp_addr,
    output logic              o_lkp_ready,
    output logic              o_lkp_rvalid,
    output logic [DATA_W-1:0] o_lkp_data,
    output logic              o_lkp_hit,
    input  logic              i_upd_valid,
    input  logic [ADDR_W-1:0] i_upd_addr,
    input  logic [DATA_W-1:0] i_upd_data,
    output logic              o_upd_ready,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic              o_ram_wren,
    output logic [DATA_W-1:0] o_ram_wdata,
    input  logic [DATA_W-1:0] i_ram_rdata
);

    localparam int PTR_W = $clog2(UPD_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [ADDR_W-1:0]  clr_cnt_q;

    logic [ADDR_W-1:0]  q_addr [UPD_DEPTH];
    logic [DATA_W-1:0]  q_data [UPD_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;

    logic               run;
    logic               q_full;
    logic               q_empty;
    logic               lkp_fire;
    logic               enq;
    logic               drain;
    logic               byp_hit;
    logic [DATA_W-1:0]  byp_data;
    logic               wren_raw;

    assign run         = (state_q == ST_RUN);
    assign q_full      = (count_q == CNT_W'(UPD_DEPTH));
    assign q_empty     = (count_q == '0);
    assign o_lkp_ready = run && !q_full;
    assign o_upd_ready = run && !q_full;
    assign o_busy      = !run;
    assign lkp_fire    = i_lkp_valid && o_lkp_ready;
    assign enq         = i_upd_valid && o_upd_ready;
    // A full queue always wins the port; otherwise lookups go first and the
    // queue drains in cycles without a lookup.
    assign drain       = run && !q_empty && (q_full || !i_lkp_valid);
    assign o_lkp_hit   = o_lkp_rvalid && o_lkp_data[DATA_W-1];
    // The write strobe is forced low while reset is asserted so the RAM is never
    // written from a half-reset controller.
    assign o_ram_wren  = wren_raw && i_rst_n;

    // FSM state register and clear sweep counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (i_flush) begin
                clr_cnt_q <= '0;
            end else if (state_q == ST_CLEAR) begin
                clr_cnt_q <= clr_cnt_q + 1'b1;
            end
        end
    end

    // Next state: leave CLEAR after the last entry, flush always restarts the sweep.
    always_comb begin
        state_d = state_q;
        if (state_q == ST_CLEAR && clr_cnt_q == '1) begin
            state_d = ST_RUN;
        end
        if (i_flush) begin
            state_d = ST_CLEAR;
        end
    end

    // RAM port mux: sweep writes, queue drain writes, or lookup reads.
    always_comb begin
        o_ram_addr  = clr_cnt_q;
        o_ram_wdata = CLR_VALUE;
        wren_raw    = 1'b0;
        if (!run) begin
            wren_raw = 1'b1;
        end else if (drain) begin
            o_ram_addr  = q_addr[rd_ptr_q];
            o_ram_wdata = q_data[rd_ptr_q];
            wren_raw    = 1'b1;
        end else begin
            o_ram_addr = i_lkp_addr;
        end
    end

    // Bypass search: walk oldest to youngest so the youngest match wins.
    always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        for (int k = 0; k < UPD_DEPTH; k++) begin
            logic [PTR_W-1:0] idx;
            idx = rd_ptr_q + PTR_W'(k);
            if (CNT_W'(k) < count_q && q_addr[idx] == i_lkp_addr) begin
                byp_hit  = 1'b1;
                byp_data = q_data[idx];
            end
        end
    end

    // Update queue pointers and occupancy; flush discards all pending updates.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (i_flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (enq) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (drain) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CNT_W'(enq) - CNT_W'(drain);
        end
    end

    // Update queue storage; contents are meaningless outside the occupied window.
    always_ff @(posedge i_clk) begin
        if (enq) begin
            q_addr[wr_ptr_q] <= i_upd_addr;
            q_data[wr_ptr_q] <= i_upd_data;
        end
    end

    // Lookup result register: one-cycle latency, bypassing queued updates.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_lkp_rvalid <= 1'b0;
            o_lkp_data   <= '0;
        end else begin
            o_lkp_rvalid <= lkp_fire && !i_flush;
            if (lkp_fire) begin
                o_lkp_data <= byp_hit ? byp_data : i_ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_btb_ctrl.sv
// tb_btb_ctrl: randomized and directed stimulus for btb_ctrl with a
// behavioural model (logical memory contents plus a pending-update list).
module tb_btb_ctrl;

    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 32;
    localparam int ENTRIES = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              lkp_valid;
    logic [ADDR_W-1:0] lkp_addr;
    logic              lkp_ready;
    logic              lkp_rvalid;
    logic [DATA_W-1:0] lkp_data;
    logic              lkp_hit;
    logic              upd_valid;
    logic [ADDR_W-1:0] upd_addr;
    logic [DATA_W-1:0] upd_data;
    logic              upd_ready;
    logic              busy;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    int n_vec = 0;
    int n_err = 0;

    // clock and reset block
    always #5 clk = ~clk;

    btb_ctrl dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_flush      (flush),
        .i_lkp_valid  (lkp_valid),
        .i_lkp_addr   (lkp_addr),
        .o_lkp_ready  (lkp_ready),
        .o_lkp_rvalid (lkp_rvalid),
        .o_lkp_data   (lkp_data),
        .o_lkp_hit    (lkp_hit),
        .i_upd_valid  (upd_valid),
        .i_upd_addr   (upd_addr),
        .i_upd_data   (upd_data),
        .o_upd_ready  (upd_ready),
        .o_busy       (busy),
        .o_ram_addr   (ram_addr),
        .o_ram_wren   (ram_wren),
        .o_ram_wdata  (ram_wdata),
        .i_ram_rdata  (ram_rdata)
    );

    // RAM array attached to the controller: synchronous write, combinational read
    logic [DATA_W-1:0] ram [ENTRIES];
    always @(posedge clk) begin
        if (ram_wren) ram[ram_addr] <= ram_wdata;
    end
    assign ram_rdata = ram[ram_addr];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // reference model state
    bit                in_clear;
    int                sweep_idx;
    bit                acc_prev;
    logic [DATA_W-1:0] lmem [ENTRIES];
    logic [ADDR_W+DATA_W-1:0] mq [$];
    logic [DATA_W-1:0] exp_q [$];

    // model: one evaluation per cycle at the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            in_clear  = 1'b1;
            sweep_idx = 0;
            acc_prev  = 1'b0;
            mq.delete();
            exp_q.delete();
            for (int i = 0; i < ENTRIES; i++) lmem[i] = '0;
        end else begin
            check("rvalid", lkp_rvalid, acc_prev);
            acc_prev = 1'b0;
            if (in_clear) begin
                check("busy_clear", busy, 1);
                check("wren_clear", ram_wren, 1);
                check("addr_clear", ram_addr, sweep_idx);
                check("wdata_clear", ram_wdata, 0);
                check("lkp_ready_clear", lkp_ready, 0);
                check("upd_ready_clear", upd_ready, 0);
                sweep_idx++;
                if (sweep_idx == ENTRIES) begin
                    in_clear  = 1'b0;
                    sweep_idx = 0;
                end
            end else begin
                bit room;
                bit do_drain;
                bit accept;
                room     = (mq.size() < 2);
                do_drain = (mq.size() == 2) || (mq.size() > 0 && !lkp_valid);
                accept   = lkp_valid && room;
                check("busy_run", busy, 0);
                check("lkp_ready", lkp_ready, room);
                check("upd_ready", upd_ready, room);
                check("wren_run", ram_wren, do_drain);
                if (do_drain) begin
                    check("drain_addr", ram_addr, mq[0][ADDR_W+DATA_W-1:DATA_W]);
                    check("drain_data", ram_wdata, mq[0][DATA_W-1:0]);
                end else if (accept) begin
                    check("lkp_port_addr", ram_addr, lkp_addr);
                end
                if (accept && !flush) begin
                    exp_q.push_back(lmem[lkp_addr]);
                    acc_prev = 1'b1;
                end
                if (do_drain) void'(mq.pop_front());
                if (upd_valid && room) begin
                    lmem[upd_addr] = upd_data;
                    mq.push_back({upd_addr, upd_data});
                end
            end
            if (flush) begin
                in_clear  = 1'b1;
                sweep_idx = 0;
                acc_prev  = 1'b0;
                mq.delete();
                for (int i = 0; i < ENTRIES; i++) lmem[i] = '0;
            end
        end
    end

    // monitor: compares every presented lookup result against the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (lkp_rvalid) begin
                if (exp_q.size() == 0) begin
                    check("rvalid_unexpected", lkp_rvalid, 0);
                end else begin
                    logic [DATA_W-1:0] e;
                    e = exp_q.pop_front();
                    check("lkp_data", lkp_data, e);
                    check("lkp_hit", lkp_hit, e[DATA_W-1]);
                end
            end else begin
                check("lkp_hit_idle", lkp_hit, 0);
            end
        end
    end

    // driver tasks
    task automatic step(input bit lv, input int la, input bit uv, input int ua,
                        input logic [DATA_W-1:0] ud, input bit fl);
        lkp_valid = lv;
        lkp_addr  = ADDR_W'(la);
        upd_valid = uv;
        upd_addr  = ADDR_W'(ua);
        upd_data  = ud;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, 0);
    endtask

    task automatic rand_steps(input int n, input bit with_upd);
        for (int i = 0; i < n; i++) begin
            logic [DATA_W-1:0] d;
            int a;
            d = $urandom;
            a = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, ENTRIES - 1))
                                            : int'($urandom_range(0, 15));
            step(bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                 with_upd && ($urandom_range(0, 2) == 0), a, d, 0);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_wren"}, ram_wren, 0);
        check({tag, "_addr"}, ram_addr, 0);
        check({tag, "_rvalid"}, lkp_rvalid, 0);
        check({tag, "_data"}, lkp_data, 0);
        check({tag, "_hit"}, lkp_hit, 0);
        check({tag, "_upd_ready"}, upd_ready, 0);
        check({tag, "_lkp_ready"}, lkp_ready, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        lkp_valid = 0; lkp_addr = '0; upd_valid = 0; upd_addr = '0; upd_data = '0; flush = 0;
        repeat (3) @(posedge clk);
        #2;
        check_reset_vals("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // sweep after reset, with lookups and updates offered but refused
        rand_steps(ENTRIES + 6, 1'b1);

        // entries with and without the valid bit, then lookups of them
        step(0, 0, 1, 12'h005, 32'h8000_1234, 0);
        step(0, 0, 1, 12'h006, 32'h0000_0040, 0);
        idle(2);
        step(1, 12'h005, 0, 0, '0, 0);
        step(1, 12'h006, 0, 0, '0, 0);
        idle(2);

        // continuous lookups: queue fills, one forced drain, lookups resume
        step(1, 12'h001, 1, 12'h010, 32'h8000_0100, 0);
        step(1, 12'h010, 1, 12'h011, 32'h8000_0110, 0);
        step(1, 12'h010, 0, 0, '0, 0);
        step(1, 12'h011, 0, 0, '0, 0);
        step(1, 12'h010, 0, 0, '0, 0);
        idle(3);

        // repeated address in the queue: youngest entry must be returned
        step(1, 12'h020, 1, 12'h020, 32'h8000_0AAA, 0);
        step(1, 12'h020, 1, 12'h020, 32'h8000_0BBB, 0);
        step(1, 12'h020, 0, 0, '0, 0);
        step(1, 12'h020, 0, 0, '0, 0);
        idle(3);
        step(1, 12'h020, 0, 0, '0, 0);
        idle(2);

        rand_steps(1500, 1'b1);
        idle(4);

        // flush with one queued update held back by lookups, then flush mid-sweep
        step(1, 12'h002, 1, 12'h030, 32'h8000_0300, 0);
        step(1, 12'h003, 0, 0, '0, 0);
        step(1, 12'h030, 0, 0, '0, 1);
        idle(500);
        step(0, 0, 0, 0, '0, 1);
        idle(ENTRIES + 4);
        step(1, 12'h030, 0, 0, '0, 0);
        idle(2);
        check("flushed_entry", ram[12'h030], 0);

        rand_steps(400, 1'b1);
        idle(4);
        for (int i = 0; i < ENTRIES; i++) begin
            if (ram[i] !== lmem[i]) check("ram_final", ram[i], lmem[i]);
        end
        n_vec++;

        // asynchronous reset mid-run while a lookup result is presented
        step(1, 12'h005, 0, 0, '0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rand_steps(ENTRIES + 40, 1'b1);
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
